pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Sequencer downstream of the rPLL; consumes its `lock` output and drives its `reset` input.
- Pulses PLL reset after power-up and confirms lock is stable.
- Retries on lock timeout, declares a sticky fault after too many retries.
- Produces a registered `sys_reset` request plus status flags for downstream reset synchronizers and the ESP32 status interface.
- Runs entirely in the 27 MHz input clock domain, which is alive even when the PLL is not.

Parameters:
- RST_PULSE_CYC, 32, cycles that pll_reset is held high per attempt (≥2)
- LOCK_TIMEOUT_CYC, 27000, cycles allowed in WAIT_LOCK before retry (1 ms at 27 MHz)
- LOCK_STABLE_CYC, 2700, consecutive synchronized-lock-high cycles required before RUN (100 us)
- MAX_RETRY, 7, timeouts tolerated before FAULT (1..2**RETRY_W-1)
- RETRY_W, 3, width of retry_cnt

Ports:
- clkin  in  1  27 MHz reference clock; sole clock of the block
- reset  in  1  asynchronous, active-high reset
- pll_lock  in  1  raw PLL lock, asynchronous to clkin
- pll_reset  out  1  reset to PLL, active-high
- pll_ready  out  1  high while in RUN
- sys_reset  out  1  active-high system reset request; always the inverse of pll_ready
- fault  out  1  sticky; high in FAULT
- retry_cnt  out  RETRY_W  timeouts counted in the current attempt sequence
- lock_lost  out  1  one-cycle pulse when lock drops during RUN

Behaviour:
- Interface: one clock (clkin); reset is asynchronous and active-high (reset).
- All outputs are registered.
- Reset values:
  - state=RESET_PLL, pll_reset=1, pll_ready=0, sys_reset=1, fault=0, retry_cnt=0, lock_lost=0
  - sync flops=0, timer=0
- pll_lock passes through a 2-flop synchronizer; lock_s lags pll_lock by 2 clkin edges. All decisions use lock_s only.
- One shared timer is used by every state. It clears to 0 on every state entry and increments each cycle in the state.
- RESET_PLL:
  - pll_reset=1.
  - When timer==RST_PULSE_CYC-1, go to WAIT_LOCK.
  - pll_reset is therefore high exactly RST_PULSE_CYC cycles, counted from reset release or from state entry.
- WAIT_LOCK:
  - pll_reset=0.
  - If lock_s=1, go to STABLE.
  - Else if timer==LOCK_TIMEOUT_CYC-1, increment retry_cnt. If the new value equals MAX_RETRY, go to FAULT; otherwise go to RESET_PLL.
  - If lock_s rises in the same cycle as the timeout, the lock wins and the block goes to STABLE.
- STABLE:
  - pll_reset=0.
  - If lock_s=0, return to WAIT_LOCK. The timer clears, so the full timeout restarts; retry_cnt is unchanged.
  - If lock_s=1 and timer==LOCK_STABLE_CYC-1, go to RUN.
- RUN:
  - pll_ready=1, sys_reset=0, pll_reset=0. The flags update on the RUN-entry edge.
  - On lock_s=0: lock_lost=1 for exactly one cycle, retry_cnt clears to 0 (fresh retry budget), next state RESET_PLL.
  - pll_ready falls and sys_reset rises on that same edge.
- FAULT:
  - pll_reset=1, fault=1, sys_reset=1, pll_ready=0.
  - lock_s is ignored.
  - Only reset exits FAULT.
- retry_cnt saturates at MAX_RETRY and never wraps.
- Reset asserted mid-operation: all registers return to reset values immediately (async). A full RST_PULSE_CYC pulse follows release.
- Timer width is clog2 of the largest of the three cycle parameters.
- Glitches on pll_lock shorter than one clkin period may be missed. This is acceptable, because STABLE filters lock chatter.

Decomposition:
- Package pll_sup_pkg contains:
  - the state enum: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT
  - a function that computes timer width from the three cycle parameters
- Sub-module sync_2ff: a generic 2-flop synchronizer with async active-high reset to 0. It is reused later for other ESP32-side inputs.

Test Plan:
All scenarios use RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, MAX_RETRY=3.
1. Release reset with pll_lock tied 1:
   - pll_reset high for cycles 0..3, low at cycle 4
   - pll_ready rises at cycle 4+2+1+8 (±1, fixed by RTL and checked exactly)
   - sys_reset = ~pll_ready throughout
2. pll_lock tied 0:
   - three 20-cycle WAIT_LOCK windows, each preceded by a 4-cycle pll_reset pulse
   - retry_cnt steps 1, 2, 3
   - fault=1 and pll_reset=1 latched; fault stays high for 100 further cycles
3. Lock chatter: pll_lock high for 5 cycles then low for 3, repeated once, then held high:
   - pll_ready stays 0 through both dropouts
   - pll_ready rises only after 8 consecutive lock_s-high cycles
   - retry_cnt=0
4. In RUN with retry_cnt=2 from earlier timeouts, drop pll_lock:
   - lock_lost pulses exactly 1 cycle, arriving 2–3 cycles after the drop
   - retry_cnt clears to 0, pll_reset pulses for 4 cycles, pll_ready falls on the same edge
5. Assert reset asynchronously mid-STABLE and mid-FAULT:
   - all outputs take reset values without waiting for a clkin edge
   - fault clears, and a full 4-cycle pll_reset pulse follows release
6. pll_lock rises so that lock_s=1 exactly on the timeout cycle: the block enters STABLE and retry_cnt is not incremented.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Purpose: shared types and sizing helpers for the PLL lock supervisor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } sup_state_t;

  // One timer serves every state, so it must reach the largest cycle count minus one.
  function automatic int timer_width(input int rst_cyc, input int timeout_cyc, input int stable_cyc);
    int m;
    m = rst_cyc;
    if (timeout_cyc > m) m = timeout_cyc;
    if (stable_cyc > m) m = stable_cyc;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: generic two-flop synchronizer for asynchronous level inputs.
// Latency: output follows input after two clk edges.
// Backpressure: none; level signals only, sub-cycle glitches may be missed.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture; the first stage may go metastable and is never used directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Purpose: pulses PLL reset, qualifies lock, retries on timeout and latches a fault.
// Latency: lock decisions lag pll_lock by two edges; all outputs registered (one edge after decision).
// Backpressure: none; free-running sequencer on the always-alive reference clock.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 32,
  parameter int LOCK_TIMEOUT_CYC = 27000,
  parameter int LOCK_STABLE_CYC  = 2700,
  parameter int MAX_RETRY        = 7,
  parameter int RETRY_W          = 3
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic               pll_ready,
  output logic               sys_reset,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lock_lost
);

  localparam int TW = timer_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
  localparam logic [TW-1:0]      RST_LAST     = TW'(RST_PULSE_CYC - 1);
  localparam logic [TW-1:0]      TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]      STABLE_LAST  = TW'(LOCK_STABLE_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

  logic               lock_s;
  sup_state_t         state;
  sup_state_t         state_nxt;
  logic [TW-1:0]      timer;
  logic [RETRY_W-1:0] retry_nxt;
  logic               lost_nxt;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Next-state, retry bookkeeping and lock-loss detection; lock wins over a coincident timeout.
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    lost_nxt  = 1'b0;
    case (state)
      RESET_PLL: begin
        if (timer == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (timer == TIMEOUT_LAST) begin
          if (retry_cnt != RETRY_MAX) retry_nxt = retry_cnt + 1'b1;
          state_nxt = (retry_nxt == RETRY_MAX) ? FAULT : RESET_PLL;
        end
      end
      STABLE: begin
        if (!lock_s) state_nxt = WAIT_LOCK;
        else if (timer == STABLE_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          lost_nxt  = 1'b1;
          retry_nxt = '0;
          state_nxt = RESET_PLL;
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = RESET_PLL;
      end
    endcase
  end

  // State register and shared timer, which restarts from zero on every state change.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state <= RESET_PLL;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= (state_nxt != state) ? '0 : timer + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      pll_reset <= 1'b1;
      pll_ready <= 1'b0;
      sys_reset <= 1'b1;
      fault     <= 1'b0;
      retry_cnt <= '0;
      lock_lost <= 1'b0;
    end else begin
      pll_reset <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
      pll_ready <= (state_nxt == RUN);
      sys_reset <= (state_nxt != RUN);
      fault     <= (state_nxt == FAULT);
      retry_cnt <= retry_nxt;
      lock_lost <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Purpose: self-checking bench for pll_lock_supervisor with a behavioural reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_lock_supervisor;

  localparam int RP = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int MR = 3;
  localparam int RW = 3;

  logic          clkin    = 1'b0;
  logic          reset    = 1'b0;
  logic          pll_lock = 1'b0;
  logic          pll_reset;
  logic          pll_ready;
  logic          sys_reset;
  logic          fault;
  logic [RW-1:0] retry_cnt;
  logic          lock_lost;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYC    (RP),
    .LOCK_TIMEOUT_CYC (TO),
    .LOCK_STABLE_CYC  (ST),
    .MAX_RETRY        (MR),
    .RETRY_W          (RW)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .pll_ready (pll_ready),
    .sys_reset (sys_reset),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .lock_lost (lock_lost)
  );

  always #5 clkin = ~clkin;

  // Edges seen since the last reset release.
  always @(posedge clkin or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Reference model: phases with a count of completed cycles; lock seen through a 2-deep delay queue.
  localparam int M_PULSE = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_FAULT = 4;
  int m_phase   = M_PULSE;
  int m_elapsed = 0;
  int m_retry   = 0;
  bit m_lost    = 0;
  bit lq[$];

  always @(posedge clkin or posedge reset) begin
    bit ls;
    int nxt;
    if (reset) begin
      m_phase = M_PULSE; m_elapsed = 0; m_retry = 0; m_lost = 0;
      lq.delete(); lq.push_back(1'b0); lq.push_back(1'b0);
    end else begin
      ls = lq.pop_front();
      lq.push_back(pll_lock);
      m_lost = 0;
      nxt = m_phase;
      m_elapsed++;
      case (m_phase)
        M_PULSE: if (m_elapsed == RP) nxt = M_WAIT;
        M_WAIT: begin
          if (ls) nxt = M_STAB;
          else if (m_elapsed == TO) begin
            m_retry = (m_retry < MR) ? m_retry + 1 : MR;
            nxt = (m_retry == MR) ? M_FAULT : M_PULSE;
          end
        end
        M_STAB: begin
          if (!ls) nxt = M_WAIT;
          else if (m_elapsed == ST) nxt = M_RUN;
        end
        M_RUN: if (!ls) begin m_lost = 1; m_retry = 0; nxt = M_PULSE; end
        default: ;
      endcase
      if (nxt != m_phase) m_elapsed = 0;
      m_phase = nxt;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t cyc=%0d actual=%0d required=%0d", nm, $time, cyc, act, exp);
    end
  endtask

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clkin) begin
    if ($time > 2) begin
      chk("cmp_pll_reset", 32'(pll_reset), 32'((m_phase == M_PULSE) || (m_phase == M_FAULT)));
      chk("cmp_pll_ready", 32'(pll_ready), 32'(m_phase == M_RUN));
      chk("cmp_sys_reset", 32'(sys_reset), 32'(m_phase != M_RUN));
      chk("cmp_fault",     32'(fault),     32'(m_phase == M_FAULT));
      chk("cmp_retry_cnt", 32'(retry_cnt), 32'(m_retry));
      chk("cmp_lock_lost", 32'(lock_lost), 32'(m_lost));
    end
  end

  task automatic to_cyc(input int n);
    int g = 0;
    while (cyc != n && g < 3000) begin
      @(posedge clkin); #1;
      g++;
    end
    if (cyc != n) begin
      n_chk++; n_bad++;
      $display("FAIL to_cyc actual=%0d required=%0d", cyc, n);
    end
  endtask

  // Holds reset for two cycles and releases mid-period; cyc is 0 on return.
  task automatic do_reset(input logic lk);
    reset = 1'b1;
    pll_lock = lk;
    repeat (2) @(negedge clkin);
    #2 reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
    chk({tag, "_pll_ready"}, 32'(pll_ready), 32'd0);
    chk({tag, "_sys_reset"}, 32'(sys_reset), 32'd1);
    chk({tag, "_fault"},     32'(fault),     32'd0);
    chk({tag, "_retry"},     32'(retry_cnt), 32'd0);
    chk({tag, "_lost"},      32'(lock_lost), 32'd0);
  endtask

  // Called 1 time unit after an edge: asserts reset between edges, checks, releases before the next edge.
  task automatic async_reset_pulse(input string tag);
    #1 reset = 1'b1;
    #1 chk_reset_vals(tag);
    #1 reset = 1'b0;
  endtask

  initial begin
    #600000;
    n_bad++;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    @(negedge clkin); #1;
    chk_reset_vals("rst_init");

    // Lock tied high: lock_s is already high when WAIT_LOCK is entered at cycle 4.
    do_reset(1'b1);
    to_cyc(3);  chk("s1_rst_hi", 32'(pll_reset), 32'd1);
    to_cyc(4);  chk("s1_rst_lo", 32'(pll_reset), 32'd0);
    to_cyc(12); chk("s1_ready_pre", 32'(pll_ready), 32'd0);
    to_cyc(13); chk("s1_ready", 32'(pll_ready), 32'd1);
    chk("s1_sys_reset", 32'(sys_reset), 32'd0);

    // PLL-like lock that only rises once pll_reset is released: ready at 4+2+1+8.
    do_reset(1'b0);
    for (int i = 0; i <= 16; i++) begin
      to_cyc(i);
      pll_lock = ~pll_reset;
      if (i == 14) chk("s1b_ready_pre", 32'(pll_ready), 32'd0);
      if (i == 15) chk("s1b_ready", 32'(pll_ready), 32'd1);
    end

    // Lock never arrives: three timeouts then sticky fault, then async reset inside FAULT.
    do_reset(1'b0);
    to_cyc(23); chk("s2_retry0", 32'(retry_cnt), 32'd0);
    to_cyc(24); chk("s2_retry1", 32'(retry_cnt), 32'd1);
    chk("s2_pulse1", 32'(pll_reset), 32'd1);
    to_cyc(48); chk("s2_retry2", 32'(retry_cnt), 32'd2);
    to_cyc(71); chk("s2_fault_pre", 32'(fault), 32'd0);
    to_cyc(72); chk("s2_fault", 32'(fault), 32'd1);
    chk("s2_retry3", 32'(retry_cnt), 32'd3);
    chk("s2_fault_rst", 32'(pll_reset), 32'd1);
    pll_lock = 1'b1;
    to_cyc(172); chk("s2_fault_held", 32'(fault), 32'd1);
    pll_lock = 1'b0;
    async_reset_pulse("s5_fault");
    to_cyc(3); chk("s5f_rst_hi", 32'(pll_reset), 32'd1);
    to_cyc(4); chk("s5f_rst_lo", 32'(pll_reset), 32'd0);

    // Lock chatter filtered by STABLE: 5 high, 3 low, 5 high, 3 low, then high.
    do_reset(1'b0);
    to_cyc(4);  pll_lock = 1'b1;
    to_cyc(9);  pll_lock = 1'b0;
    to_cyc(12); pll_lock = 1'b1;
    to_cyc(17); pll_lock = 1'b0;
    to_cyc(20); pll_lock = 1'b1;
    chk("s3_ready_mid", 32'(pll_ready), 32'd0);
    to_cyc(30); chk("s3_ready_pre", 32'(pll_ready), 32'd0);
    to_cyc(31); chk("s3_ready", 32'(pll_ready), 32'd1);
    chk("s3_retry", 32'(retry_cnt), 32'd0);

    // Reach RUN with two retries used, then lose lock.
    do_reset(1'b0);
    to_cyc(52); pll_lock = 1'b1;
    to_cyc(63); chk("s4_run", 32'(pll_ready), 32'd1);
    chk("s4_retry2", 32'(retry_cnt), 32'd2);
    to_cyc(70); pll_lock = 1'b0;
    to_cyc(72); chk("s4_lost_pre", 32'(lock_lost), 32'd0);
    to_cyc(73); chk("s4_lost", 32'(lock_lost), 32'd1);
    chk("s4_retry_clr", 32'(retry_cnt), 32'd0);
    chk("s4_ready_fall", 32'(pll_ready), 32'd0);
    chk("s4_pulse", 32'(pll_reset), 32'd1);
    to_cyc(74); chk("s4_lost_end", 32'(lock_lost), 32'd0);
    to_cyc(76); chk("s4_pulse_end", 32'(pll_reset), 32'd1);
    to_cyc(77); chk("s4_pulse_off", 32'(pll_reset), 32'd0);

    // Async reset in the middle of STABLE.
    do_reset(1'b1);
    to_cyc(8);
    async_reset_pulse("s5_stable");
    to_cyc(3); chk("s5s_rst_hi", 32'(pll_reset), 32'd1);
    to_cyc(4); chk("s5s_rst_lo", 32'(pll_reset), 32'd0);

    // lock_s first high on the timeout cycle (23): lock wins.
    do_reset(1'b0);
    to_cyc(21); pll_lock = 1'b1;
    to_cyc(24); chk("s6_retry", 32'(retry_cnt), 32'd0);
    chk("s6_no_pulse", 32'(pll_reset), 32'd0);
    to_cyc(32); chk("s6_ready", 32'(pll_ready), 32'd1);

    // One cycle later the timeout wins instead.
    do_reset(1'b0);
    to_cyc(22); pll_lock = 1'b1;
    to_cyc(24); chk("s6b_retry", 32'(retry_cnt), 32'd1);
    chk("s6b_pulse", 32'(pll_reset), 32'd1);
    to_cyc(37); chk("s6b_ready", 32'(pll_ready), 32'd1);

    // Randomized lock runs with occasional asynchronous resets.
    do_reset(1'b0);
    for (int k = 0; k < 150; k++) begin
      int len;
      len = $urandom_range(1, 45);
      pll_lock = 1'($urandom_range(0, 1));
      repeat (len) begin
        @(posedge clkin); #1;
      end
      if ($urandom_range(0, 24) == 0) async_reset_pulse("rnd_rst");
    end

    repeat (2) @(posedge clkin);
    #1;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
